pipe_hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage miniRV core (IF/ID/EX/MEM/WB).
- Drives stall and flush controls of the PC and of the IF_ID, ID_EX and EX_MEN stage registers.
- Generates EX-stage operand forwarding selects and sequences boot hold and multi-cycle DRAM waits.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_if.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the miniRV pipeline datapath and pipe_hazard_ctrl.
// The pipeline side drives the stage status (master); the controller returns stall/flush/forward controls (slave).
interface pipe_hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rR1;
  logic [4:0]       id_rR2;
  logic             id_re1;
  logic             id_re2;
  logic [4:0]       ex_wR;
  logic             ex_rf_we;
  logic [1:0]       ex_rf_wsel;
  logic [4:0]       men_wR;
  logic             men_rf_we;
  logic [4:0]       wb_wR;
  logic             wb_rf_we;
  logic             ex_br_taken;
  logic             men_req;
  logic             men_ready;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_stall;
  logic             ex_men_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rR1, id_rR2, id_re1, id_re2,
    output ex_wR, ex_rf_we, ex_rf_wsel,
    output men_wR, men_rf_we, wb_wR, wb_rf_we,
    output ex_br_taken, men_req, men_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_men_stall,
    input  if_id_flush, id_ex_flush, fwd_a_sel, fwd_b_sel,
    input  mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rR1, id_rR2, id_re1, id_re2,
    input  ex_wR, ex_rf_we, ex_rf_wsel,
    input  men_wR, men_rf_we, wb_wR, wb_rf_we,
    input  ex_br_taken, men_req, men_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_men_stall,
    output if_id_flush, id_ex_flush, fwd_a_sel, fwd_b_sel,
    output mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage miniRV pipeline: boot hold, DRAM freeze,
// branch flush, load-use bubble, EX operand forwarding and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int         BOOT_CYC  = 2,
  parameter int         MAX_WAIT  = 16,
  parameter logic [1:0] WSEL_DRAM = 2'b01,
  parameter int         CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_hazard_if.slave hz
);

  typedef enum logic [1:0] {BOOT, RUN, MWAIT} state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYC - 1);
  localparam logic [7:0] WAIT_MAX  = 8'(MAX_WAIT);

  state_t           state, state_nxt;
  logic [3:0]       boot_cnt;
  logic [7:0]       wait_cnt, wait_nxt;
  logic             timeout_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  logic       pc_stall, if_id_stall, id_ex_stall, ex_men_stall;
  logic       if_id_flush, id_ex_flush, br_flush, freeze, load_use;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_wait(input logic [7:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + 8'd1;
  endfunction

  // Youngest producer wins; a load in EX has no data yet, so it is never an EX source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rr, input logic re);
    logic [1:0] sel;
    sel = 2'b00;
    if (re && rr != 5'd0) begin
      if (hz.ex_rf_we && hz.ex_wR == rr && hz.ex_rf_wsel != WSEL_DRAM) sel = 2'b01;
      else if (hz.men_rf_we && hz.men_wR == rr)                         sel = 2'b10;
      else if (hz.wb_rf_we && hz.wb_wR == rr)                           sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = hz.ex_rf_we && hz.ex_rf_wsel == WSEL_DRAM && hz.ex_wR != 5'd0 &&
               ((hz.id_re1 && hz.id_rR1 == hz.ex_wR) || (hz.id_re2 && hz.id_rR2 == hz.ex_wR));
    freeze   = (state == RUN && hz.men_req && !hz.men_ready) ||
               (state == MWAIT && !hz.men_ready);
  end

  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_men_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    br_flush     = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    case (state)
      BOOT: begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (boot_cnt == BOOT_LAST) state_nxt = RUN;
      end
      RUN, MWAIT: begin
        fwd_a = fwd_sel(hz.id_rR1, hz.id_re1);
        fwd_b = fwd_sel(hz.id_rR2, hz.id_re2);
        if (freeze) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_men_stall = 1'b1;
          if (state == RUN) begin
            state_nxt = MWAIT;
            wait_nxt  = 8'd1;
          end else begin
            wait_nxt  = sat_wait(wait_cnt);
          end
        end else begin
          if (state == MWAIT) begin
            state_nxt = RUN;
            wait_nxt  = 8'd0;
          end
          // The instruction in ID is on the wrong path when a branch resolves, so its hazard is moot.
          if (hz.ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_flush    = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BOOT;
      boot_cnt    <= 4'd0;
      wait_cnt    <= 8'd0;
      timeout_r   <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= (state == BOOT) ? boot_cnt + 4'd1 : 4'd0;
      wait_cnt <= wait_nxt;
      if (freeze && wait_nxt == WAIT_MAX) timeout_r <= 1'b1;
      if (pc_stall) stall_cnt_r <= sat_inc(stall_cnt_r);
      if (br_flush) flush_cnt_r <= sat_inc(flush_cnt_r);
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.id_ex_stall  = id_ex_stall;
  assign hz.ex_men_stall = ex_men_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.fwd_a_sel    = fwd_a;
  assign hz.fwd_b_sel    = fwd_b;
  assign hz.mem_timeout  = timeout_r;
  assign hz.stall_cnt    = stall_cnt_r;
  assign hz.flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: boot hold, load-use, forwarding, branch flush,
// DRAM freeze and sticky timeout, with hand-computed expected values.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  pipe_hazard_if #(.CNT_W(32)) hz ();

  pipe_hazard_ctrl #(
    .BOOT_CYC (2),
    .MAX_WAIT (4),
    .WSEL_DRAM(2'b01),
    .CNT_W    (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    hz.id_rR1 = 5'd0; hz.id_rR2 = 5'd0; hz.id_re1 = 1'b0; hz.id_re2 = 1'b0;
    hz.ex_wR = 5'd0; hz.ex_rf_we = 1'b0; hz.ex_rf_wsel = 2'b00;
    hz.men_wR = 5'd0; hz.men_rf_we = 1'b0; hz.wb_wR = 5'd0; hz.wb_rf_we = 1'b0;
    hz.ex_br_taken = 1'b0; hz.men_req = 1'b0; hz.men_ready = 1'b0;
  endtask

  // Advance one clock and land 1 time unit after the edge, then let inputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs the six stall/flush controls as {pc,if_id_s,id_ex_s,ex_men_s,if_id_f,id_ex_f}.
  function automatic logic [31:0] ctl();
    return {26'd0, hz.pc_stall, hz.if_id_stall, hz.id_ex_stall, hz.ex_men_stall,
            hz.if_id_flush, hz.id_ex_flush};
  endfunction

  task automatic set_load_use();
    hz.ex_rf_we = 1'b1; hz.ex_rf_wsel = 2'b01; hz.ex_wR = 5'd5;
    hz.id_re1 = 1'b1; hz.id_rR1 = 5'd5;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    tick(); tick();
    #1;
    chk("rst_stall_cnt", hz.stall_cnt, 32'd0);
    chk("rst_flush_cnt", hz.flush_cnt, 32'd0);
    chk("rst_timeout",   {31'd0, hz.mem_timeout}, 32'd0);
    chk("rst_boot_ctl",  ctl(), 32'b100011);

    // Boot hold for exactly two cycles
    rst = 1'b1;
    #1;
    chk("boot0_ctl", ctl(), 32'b100011);
    tick(); #1;
    chk("boot1_ctl", ctl(), 32'b100011);
    chk("boot1_fwd", {30'd0, hz.fwd_a_sel}, 32'd0);
    tick(); #1;
    chk("run_ctl",   ctl(), 32'd0);
    chk("boot_stall_cnt", hz.stall_cnt, 32'd2);

    // Load-use: one bubble, then MEM forwarding
    set_load_use();
    #1;
    chk("lu_ctl",   ctl(), 32'b110001);
    chk("lu_fwd_a", {30'd0, hz.fwd_a_sel}, 32'd0);
    tick();
    hz.ex_rf_we = 1'b0; hz.ex_wR = 5'd0; hz.ex_rf_wsel = 2'b00;
    hz.men_rf_we = 1'b1; hz.men_wR = 5'd5;
    #1;
    chk("lu_next_ctl",   ctl(), 32'd0);
    chk("lu_next_fwd_a", {30'd0, hz.fwd_a_sel}, 32'd2);
    chk("lu_stall_cnt",  hz.stall_cnt, 32'd3);

    // Forwarding priority and zero register
    idle();
    hz.ex_rf_we = 1'b1; hz.ex_wR = 5'd3; hz.ex_rf_wsel = 2'b00;
    hz.men_rf_we = 1'b1; hz.men_wR = 5'd3;
    hz.id_re2 = 1'b1; hz.id_rR2 = 5'd3;
    hz.wb_rf_we = 1'b1; hz.wb_wR = 5'd7;
    hz.id_re1 = 1'b1; hz.id_rR1 = 5'd7;
    #1;
    chk("fwd_b_ex",  {30'd0, hz.fwd_b_sel}, 32'd1);
    chk("fwd_a_wb",  {30'd0, hz.fwd_a_sel}, 32'd3);
    chk("fwd_ctl",   ctl(), 32'd0);
    hz.ex_rf_wsel = 2'b01;
    #1;
    chk("fwd_b_load_skips_ex", {30'd0, hz.fwd_b_sel}, 32'd2);
    hz.ex_rf_wsel = 2'b00; hz.id_rR2 = 5'd0; hz.id_re1 = 1'b0;
    #1;
    chk("fwd_b_x0",     {30'd0, hz.fwd_b_sel}, 32'd0);
    chk("fwd_a_unused", {30'd0, hz.fwd_a_sel}, 32'd0);

    // Branch beats a coincident load-use
    idle();
    set_load_use();
    hz.ex_br_taken = 1'b1;
    #1;
    chk("br_ctl", ctl(), 32'b000011);
    tick(); idle(); #1;
    chk("br_flush_cnt", hz.flush_cnt, 32'd1);
    chk("br_stall_cnt", hz.stall_cnt, 32'd3);

    // DRAM freeze for 3 cycles with a branch held in EX; release flushes it
    hz.men_req = 1'b1; hz.men_ready = 1'b0; hz.ex_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("frz%0d_ctl", i), ctl(), 32'b111100);
      tick();
    end
    hz.men_ready = 1'b1;
    #1;
    chk("frz_release_ctl", ctl(), 32'b000011);
    chk("frz_timeout", {31'd0, hz.mem_timeout}, 32'd0);
    tick(); idle(); #1;
    chk("frz_after_ctl",   ctl(), 32'd0);
    chk("frz_stall_cnt",   hz.stall_cnt, 32'd6);
    chk("frz_flush_cnt",   hz.flush_cnt, 32'd2);

    // Timeout after 4 wait cycles, sticky through release
    hz.men_req = 1'b1; hz.men_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("to%0d_ctl", i), ctl(), 32'b111100);
      chk($sformatf("to%0d_flag", i), {31'd0, hz.mem_timeout}, (i >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    hz.men_ready = 1'b1;
    #1;
    chk("to_release_ctl",  ctl(), 32'd0);
    chk("to_release_flag", {31'd0, hz.mem_timeout}, 32'd1);
    tick(); idle(); #1;
    chk("to_sticky_flag",  {31'd0, hz.mem_timeout}, 32'd1);
    chk("to_stall_cnt",    hz.stall_cnt, 32'd12);

    // Reset clears the sticky flag and counters, returns to boot
    rst = 1'b0;
    tick(); #1;
    chk("rst2_flag",      {31'd0, hz.mem_timeout}, 32'd0);
    chk("rst2_stall_cnt", hz.stall_cnt, 32'd0);
    chk("rst2_flush_cnt", hz.flush_cnt, 32'd0);
    chk("rst2_ctl",       ctl(), 32'b100011);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
